// File: rtl/adc_128s_fc_pkg.sv
// Shared constants for the ADC128S-style SPI responder: channel addresses and widths.
// Imported by the top level; the edge synchronizer needs nothing from here.
package adc_128s_fc_pkg;

    localparam int DATA_W  = 12;
    localparam int FRAME_W = 16;
    localparam int CNT_W   = 5;
    localparam int ADDR_W  = 3;

    // Address field position inside the received command word
    localparam int ADDR_MSB = 13;
    localparam int ADDR_LSB = 11;

    localparam logic [ADDR_W-1:0] CH_LFT   = 3'd0;
    localparam logic [ADDR_W-1:0] CH_RGHT  = 3'd4;
    localparam logic [ADDR_W-1:0] CH_STEER = 3'd5;
    localparam logic [ADDR_W-1:0] CH_BATT  = 3'd6;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

endpackage

// File: rtl/adc_128s_fc_if.sv
// SPI pins between a bus master and the ADC responder.
// Names follow the board-level pin names.
interface adc_128s_fc_if;

    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (
        output SS_n,
        output SCLK,
        output MOSI,
        input  MISO
    );

    modport slave (
        input  SS_n,
        input  SCLK,
        input  MOSI,
        output MISO
    );

endinterface

// File: rtl/adc_128s_fc_spi_edge_sync.sv
// Two-flop synchronizer plus an edge flop; rise/fall pulse one clk, 3 clk after the pin moves.
// No backpressure: every settled level change produces exactly one pulse.
module spi_edge_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic sync_q1;
    logic sync_q2;
    logic edge_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= RST_VAL;
            sync_q2 <= RST_VAL;
            edge_q  <= RST_VAL;
        end else begin
            sync_q1 <= async_in;
            sync_q2 <= sync_q1;
            edge_q  <= sync_q2;
        end
    end

    assign rise =  sync_q2 & ~edge_q;
    assign fall = ~sync_q2 &  edge_q;

endmodule

// File: rtl/adc_128s_fc.sv
// SPI mode-0 responder modelling a 16-bit-frame ADC with one-frame read latency.
// Latency: data for the address sent in frame N appears in frame N+1; no backpressure, master paces SCLK.
module adc_128s_fc
    import adc_128s_fc_pkg::*;
#(
    parameter logic [DATA_W-1:0] UNUSED_VAL = 12'h000
) (
    input  logic              clk,
    input  logic              rst,
    adc_128s_fc_if.slave      spi,
    input  logic [DATA_W-1:0] ld_cell_lft,
    input  logic [DATA_W-1:0] ld_cell_rght,
    input  logic [DATA_W-1:0] steerPot,
    input  logic [DATA_W-1:0] batt
);

    logic sclk_rise;
    logic sclk_fall;
    logic ss_rise;
    logic ss_fall;

    spi_edge_sync #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (spi.SCLK),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    spi_edge_sync #(.RST_VAL(1'b1)) u_ss_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (spi.SS_n),
        .rise     (ss_rise),
        .fall     (ss_fall)
    );

    // MOSI gets the same two-flop delay so it lines up with the detected SCLK rise
    logic mosi_q1;
    logic mosi_q2;

    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_q1 <= 1'b0;
            mosi_q2 <= 1'b0;
        end else begin
            mosi_q1 <= spi.MOSI;
            mosi_q2 <= mosi_q1;
        end
    end

    logic [ADDR_W-1:0]  ptr;
    logic [FRAME_W-1:0] tx_shift;
    logic [FRAME_W-1:0] rx_shift;
    logic [CNT_W-1:0]   rise_cnt;
    logic               in_frame;
    logic [DATA_W-1:0]  ch_val;

    always_comb begin
        ch_val = UNUSED_VAL;
        case (ptr)
            CH_LFT:   ch_val = ld_cell_lft;
            CH_RGHT:  ch_val = ld_cell_rght;
            CH_STEER: ch_val = steerPot;
            CH_BATT:  ch_val = batt;
            default:  ch_val = UNUSED_VAL;
        endcase
    end

    logic shift_ok;
    assign shift_ok = (rise_cnt != '0) && (rise_cnt < CNT_FULL);

    // Frame start wins over a coincident SCLK rise; that rise is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rise_cnt <= '0;
            in_frame <= 1'b0;
        end else if (ss_fall) begin
            tx_shift <= {{(FRAME_W-DATA_W){1'b0}}, ch_val};
            rx_shift <= '0;
            rise_cnt <= '0;
            in_frame <= 1'b1;
        end else if (ss_rise) begin
            in_frame <= 1'b0;
            if (in_frame && rise_cnt == CNT_FULL) begin
                ptr <= rx_shift[ADDR_MSB:ADDR_LSB];
            end
        end else if (in_frame) begin
            if (sclk_rise) begin
                rx_shift <= {rx_shift[FRAME_W-2:0], mosi_q2};
                if (rise_cnt != CNT_FULL) begin
                    rise_cnt <= rise_cnt + CNT_W'(1);
                end
            end
            if (sclk_fall && shift_ok) begin
                tx_shift <= {tx_shift[FRAME_W-2:0], 1'b0};
            end
        end
    end

    // Gated on the raw pin so MISO drops the moment the master deselects
    assign spi.MISO = ~spi.SS_n & tx_shift[FRAME_W-1];

endmodule

// File: tb/tb_adc_128s_fc.sv
// Scoreboarded bench for adc_128s_fc: a reference pointer model predicts each frame's response.
module tb_adc_128s_fc;

    logic        clk;
    logic        rst;
    logic [11:0] ld_cell_lft;
    logic [11:0] ld_cell_rght;
    logic [11:0] steerPot;
    logic [11:0] batt;

    adc_128s_fc_if spi_if ();

    adc_128s_fc #(.UNUSED_VAL(12'h000)) dut (
        .clk          (clk),
        .rst          (rst),
        .spi          (spi_if.slave),
        .ld_cell_lft  (ld_cell_lft),
        .ld_cell_rght (ld_cell_rght),
        .steerPot     (steerPot),
        .batt         (batt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [2:0]  model_ptr;
    logic [15:0] sb_q [$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] model_val(input logic [2:0] p);
        case (p)
            3'd0:    return ld_cell_lft;
            3'd4:    return ld_cell_rght;
            3'd5:    return steerPot;
            3'd6:    return batt;
            default: return 12'h000;
        endcase
    endfunction

    // One SPI frame: n_rise SCLK pulses; optional ld_cell_lft change at bit chg_bit;
    // optional reset pulse before deselect.
    task automatic do_frame(input string tag, input logic [15:0] word, input int n_rise,
                            input int chg_bit, input logic [11:0] chg_val, input bit rst_abort);
        logic [15:0] got;
        logic [15:0] exp;
        sb_q.push_back({4'b0000, model_val(model_ptr)});
        got = '0;
        spi_if.SS_n = 1'b0;
        tick(4);
        for (int i = 0; i < n_rise; i++) begin
            spi_if.MOSI = word[15-i];
            if (i == chg_bit) ld_cell_lft = chg_val;
            tick(8);
            got = {got[14:0], spi_if.MISO};
            spi_if.SCLK = 1'b1;
            tick(8);
            spi_if.SCLK = 1'b0;
        end
        tick(8);
        if (rst_abort) begin
            rst = 1'b1;
            tick(2);
            rst = 1'b0;
            tick(1);
        end
        spi_if.SS_n = 1'b1;
        tick(8);
        exp = sb_q.pop_front();
        exp = exp >> (16 - n_rise);
        chk(tag, got, exp);
        if (rst_abort) model_ptr = 3'd0;
        else if (n_rise == 16) model_ptr = word[13:11];
        chk({tag, "_idle_miso"}, {15'b0, spi_if.MISO}, 16'h0000);
    endtask

    initial begin
        rst          = 1'b1;
        spi_if.SS_n  = 1'b1;
        spi_if.SCLK  = 1'b0;
        spi_if.MOSI  = 1'b0;
        ld_cell_lft  = 12'h300;
        ld_cell_rght = 12'h2A5;
        steerPot     = 12'h800;
        batt         = 12'hFFF;
        model_ptr    = 3'd0;
        tick(3);
        chk("rst_miso", {15'b0, spi_if.MISO}, 16'h0000);
        rst = 1'b0;
        tick(4);
        chk("post_rst_miso", {15'b0, spi_if.MISO}, 16'h0000);

        do_frame("f_ch0",      16'h0000, 16, -1, 12'h000, 1'b0);
        do_frame("f_addr6",    16'h3000, 16, -1, 12'h000, 1'b0);
        do_frame("f_batt",     16'h2000, 16, -1, 12'h000, 1'b0);
        do_frame("f_rght",     16'h2800, 16, -1, 12'h000, 1'b0);
        do_frame("f_steer",    16'h2000, 16, -1, 12'h000, 1'b0);
        do_frame("f_rght2",    16'h0000, 16, -1, 12'h000, 1'b0);
        do_frame("f_midchg",   16'h0000, 16,  6, 12'h123, 1'b0);
        do_frame("f_newlft",   16'h2000, 16, -1, 12'h000, 1'b0);
        do_frame("f_abort",    16'h3000,  8, -1, 12'h000, 1'b0);
        do_frame("f_after_ab", 16'h1000, 16, -1, 12'h000, 1'b0);
        do_frame("f_unused",   16'h0000, 16, -1, 12'h000, 1'b0);

        // SCLK activity with SS_n high must not disturb anything
        spi_if.MOSI = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(8);
            spi_if.SCLK = 1'b1;
            tick(8);
            spi_if.SCLK = 1'b0;
        end
        chk("idle_sclk_miso", {15'b0, spi_if.MISO}, 16'h0000);

        do_frame("f_idle_ok",  16'h3000, 16, -1, 12'h000, 1'b0);
        do_frame("f_rstabort", 16'h2000,  5, -1, 12'h000, 1'b1);
        do_frame("f_after_rst",16'h0000, 16, -1, 12'h000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adc_128s_fc.md
ADC_128S_FC -- requirements
Module: adc_128s_fc

Interface
REQ-001 SHALL have parameter UNUSED_VAL, default 12'h000: conversion result returned for unmapped channels.
REQ-002 SHALL have port clk, input, 1: single system clock, rising-edge active.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port SS_n, input, 1: SPI slave select, active-low, frames one 16-bit transaction.
REQ-005 SHALL have port SCLK, input, 1: SPI serial clock, mode 0 (idle low), asynchronous to clk.
REQ-006 SHALL have port MOSI, input, 1: command bit from master, MSB first.
REQ-007 SHALL have port MISO, output, 1: response bit to master, MSB first.
REQ-008 SHALL have ports ld_cell_lft, ld_cell_rght, steerPot, batt, each input, 12: analog values for channels 0, 4, 5, 6.

Function
REQ-009 SHALL pass SCLK and SS_n through two flops plus one edge flop each; the edges SHALL be detected in the clk domain: SCLK rise, SCLK fall, SS_n fall, SS_n rise.
REQ-010 SHALL support SCLK high and low phases of at least 4 clk each; faster SCLK is out of scope.
REQ-011 Channel map SHALL be: address 0 to ld_cell_lft, 4 to ld_cell_rght, 5 to steerPot, 6 to batt; addresses 1, 2, 3 and 7 SHALL return UNUSED_VAL.
REQ-012 SHALL hold a 3-bit channel pointer ptr holding the address received in the last completed transaction.
REQ-013 On SS_n fall, SHALL load the 16-bit tx shift register with {4'b0000, value of channel ptr}; the value is sampled on that cycle and input changes later in the frame SHALL NOT affect it.
REQ-014 On SS_n fall, SHALL clear the rx shift register and the 5-bit rise counter.
REQ-015 On each SCLK rise while SS_n is low, SHALL shift MOSI into the rx register LSB and increment the rise counter, saturating at 16; MOSI is sampled from a copy delayed to match the SCLK synchronizer.
REQ-016 On each SCLK fall while SS_n is low and the rise counter is 1 to 15, SHALL shift the tx register left by one, filling with 0.
REQ-017 MISO SHALL equal tx[15] while SS_n is low and 0 while SS_n is high.
REQ-018 On SS_n rise with rise counter equal to 16, SHALL set ptr to rx[13:11]; all other rx bits SHALL be ignored.
REQ-019 On SS_n rise with rise counter below 16 (aborted frame), ptr SHALL stay unchanged.
REQ-020 Read latency SHALL be one transaction: frame N returns data for the address sent in frame N-1; the intended master use is a two-frame read (send address, then read result).
REQ-021 SCLK edges while SS_n is high SHALL be ignored.
REQ-022 If SS_n fall and SCLK rise land on the same clk, the SS_n-fall load SHALL take priority and that SCLK rise SHALL be discarded.

Reset
REQ-023 rst SHALL be sampled only on rising clk and SHALL dominate all other events.
REQ-024 On reset: ptr=0, tx=0, rx=0, rise counter=0, synchronizer flops=1 for SS_n and 0 for SCLK, MISO=0.
REQ-025 Reset during a frame SHALL abort it with no ptr update; the next SS_n fall SHALL return channel 0 data.

Structure
REQ-026 Package adc_128s_fc_pkg SHALL hold the channel address constants (CH_LFT=0, CH_RGHT=4, CH_STEER=5, CH_BATT=6) and the data and frame widths (12, 16).
REQ-027 One sub-module, spi_edge_sync, SHALL implement the synchronizer and edge detector of REQ-009 and be instantiated twice (SCLK, SS_n).
REQ-028 The remaining logic SHALL be flat in adc_128s_fc.

Verification
REQ-029 Reset, then one frame with MOSI=16'h0000 and ld_cell_lft=12'h300 -> MISO word 16'h0300.
REQ-030 Frame sending 16'h3000 (channel 6), then frame with batt=12'hFFF -> second frame returns 16'h0FFF, first returns channel-0 data.
REQ-031 Frames addressing 4, 5, 4 with ld_cell_rght=12'h2A5 and steerPot=12'h800 -> successive responses 12'h2A5, 12'h800 data after a one-frame lag.
REQ-032 ld_cell_lft changed from 12'h300 to 12'h123 mid-frame -> that frame still returns 16'h0300, the next returns 16'h0123.
REQ-033 Frame aborted after 8 SCLK rises carrying address 6 -> ptr unchanged; the next frame returns the previous channel.
REQ-034 Address 2 frame, then read -> 16'h0000 (UNUSED_VAL); MISO is 0 whenever SS_n is high.
